bitrev_stream: RTL and testbench
================================

BITREV_STREAM -- requirements
Module: bitrev_stream

Interface
REQ-001 Parameter W, default 8, data width in bits; SHALL be >= 2.
REQ-002 Parameter G, default 1, reversal group width in bits; W SHALL be a multiple of G.
REQ-003 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port mode, input, 1: 0 = parallel, 1 = serial; sampled only on input handshake.
REQ-006 Port in_valid, input, 1: in_data is valid.
REQ-007 Port in_ready, output, 1: block accepts in_data this cycle.
REQ-008 Port in_data, input, W: word to reverse.
REQ-009 Port out_valid, output, 1: rev and palind are valid.
REQ-010 Port out_ready, input, 1: consumer accepts the result.
REQ-011 Port rev, output, W: in_data with its W/G groups of G bits in reversed order; bit order within each group is preserved.
REQ-012 Port palind, output, 1: 1 when rev equals the accepted in_data.
REQ-013 Port pal_cnt, output, 16: count of palindromic results delivered.

Function
REQ-014 Input handshake SHALL be in_valid && in_ready; output handshake SHALL be out_valid && out_ready.
REQ-015 FSM SHALL have states IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 in IDLE, and in DONE only when out_ready is 1; it SHALL be 0 otherwise.
REQ-017 Parallel accept SHALL go to DONE with rev and palind registered next cycle (latency 1).
REQ-018 Serial accept SHALL go to SHIFT and move one group per cycle into rev using a group counter from 0 to W/G-1.
REQ-019 SHIFT SHALL go to DONE after exactly W/G cycles (latency W/G+1); in_valid is ignored during SHIFT.
REQ-020 out_valid SHALL be 1 only in DONE; rev and palind SHALL hold stable until the output handshake.
REQ-021 DONE with an output handshake and no input handshake SHALL return to IDLE.
REQ-022 Simultaneous output and input handshakes in DONE SHALL consume the result and accept the new word in the same cycle, then proceed per REQ-017/018 with no bubble.
REQ-023 palind SHALL be computed by comparing against a registered copy of the accepted word, not the live in_data.
REQ-024 Serial and parallel results SHALL be bit-identical for the same in_data.

Reset
REQ-025 While rst is 1: state = IDLE, group counter = 0, rev = 0, palind = 0, out_valid = 0, pal_cnt = 0.
REQ-026 Reset asserted in SHIFT or DONE SHALL discard the word in flight; no partial result SHALL appear after release.
REQ-027 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-028 Macro BITREV_PALCNT_EN defined: pal_cnt SHALL increment by 1 on each output handshake with palind = 1 and saturate at 16'hFFFF.
REQ-029 Macro BITREV_PALCNT_EN undefined: pal_cnt SHALL be the constant 0 and no counter logic SHALL be built; the port list is unchanged.

Structure
REQ-030 Package bitrev_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/DONE), the pal_cnt width constant (16) and the mode encodings.
REQ-031 Sub-module bitrev_group_rev SHALL implement the combinational group reversal (parameters W, G) and be used in the parallel path and the palindrome compare.
REQ-032 The top SHALL reject W % G != 0 at elaboration.

Verification
REQ-033 W=8, G=1, mode=0: in 8'b1101_0010 -> rev 8'b0100_1011, palind 0, out_valid one cycle after accept.
REQ-034 W=8, G=4, mode=0: in 8'hA5 -> rev 8'h5A, palind 0; in 8'h66 -> rev 8'h66, palind 1.
REQ-035 W=8, G=1, mode=1: in 8'b1000_0001 -> out_valid 9 cycles after accept, rev 8'b1000_0001, palind 1; in_ready 0 during SHIFT.
REQ-036 out_ready held 0 for 5 cycles in DONE -> rev and palind stable, in_ready 0; then out_ready=1 with in_valid=1 -> back-to-back accept, no idle cycle.
REQ-037 rst pulsed in cycle 3 of a serial SHIFT -> IDLE, out_valid 0, rev 0; the next accepted word gives a correct result.
REQ-038 BITREV_PALCNT_EN defined: 3 palindromic plus 2 non-palindromic deliveries -> pal_cnt = 3; preload near 16'hFFFF -> holds at 16'hFFFF; macro undefined -> pal_cnt stays 0.

Source files
------------

// File: rtl/bitrev_pkg.sv
// bitrev_pkg: shared FSM state type, pal_cnt width and mode encodings for bitrev_stream
package bitrev_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int PAL_CNT_W = 16;
  localparam logic MODE_PAR = 1'b0;
  localparam logic MODE_SER = 1'b1;
endpackage

// File: rtl/bitrev_stream_if.sv
// bitrev_stream_if: input/output handshake bundle for bitrev_stream
interface bitrev_stream_if #(parameter int W = 8) ();
  import bitrev_pkg::*;
  logic mode;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] rev;
  logic palind;
  logic [PAL_CNT_W-1:0] pal_cnt;
  modport master (output mode, in_valid, in_data, out_ready, input in_ready, out_valid, rev, palind, pal_cnt);
  modport slave (input mode, in_valid, in_data, out_ready, output in_ready, out_valid, rev, palind, pal_cnt);
endinterface

// File: rtl/bitrev_group_rev.sv
// bitrev_group_rev: combinational reversal of the W/G groups of G bits, group-internal order kept
module bitrev_group_rev #(parameter int W = 8, parameter int G = 1) (
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  for (genvar g = 0; g < W / G; g++) begin : g_grp
    assign q_o[(W/G-1-g)*G +: G] = d_i[g*G +: G];
  end
endmodule

// File: rtl/bitrev_stream.sv
// bitrev_stream: handshaked group reversal, parallel (1 cycle) or serial (one group per cycle); BITREV_PALCNT_EN adds a saturating palindrome counter
module bitrev_stream import bitrev_pkg::*; #(
  parameter int W = 8,
  parameter int G = 1
) (
  input logic clk,
  input logic rst,
  bitrev_stream_if.slave bus
);
  localparam int NG = W / G;
  localparam int CW = NG > 1 ? $clog2(NG) : 1;
  if (W < 2 || W % G != 0) begin : g_bad_cfg
    $error("bitrev_stream: W must be >= 2 and a multiple of G");
  end
  state_t state_q;
  logic [CW-1:0] grp_q;
  logic [W-1:0] rev_q;
  logic [W-1:0] word_q;
  logic [W-1:0] par_rev;
  logic [W-1:0] word_rev;
  logic in_acc;
  logic out_acc;
  bitrev_group_rev #(.W(W), .G(G)) u_par (.d_i(bus.in_data), .q_o(par_rev));
  bitrev_group_rev #(.W(W), .G(G)) u_pal (.d_i(word_q), .q_o(word_rev));
  assign bus.in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign bus.out_valid = state_q == DONE;
  assign bus.rev = rev_q;
  assign bus.palind = (state_q == DONE) && (word_rev == word_q);
  assign in_acc = bus.in_valid && bus.in_ready;
  assign out_acc = bus.out_valid && bus.out_ready;
  // FSM: accept a word, reverse it in one step or group by group, hold it until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grp_q <= '0;
      rev_q <= '0;
      word_q <= '0;
    end else if (in_acc) begin
      word_q <= bus.in_data;
      grp_q <= '0;
      if (bus.mode == MODE_SER) begin
        state_q <= SHIFT;
      end else begin
        rev_q <= par_rev;
        state_q <= DONE;
      end
    end else if (state_q == SHIFT) begin
      rev_q[(NG-1-int'(grp_q))*G +: G] <= word_q[int'(grp_q)*G +: G];
      grp_q <= grp_q + 1'b1;
      if (grp_q == CW'(NG - 1)) state_q <= DONE;
    end else if (out_acc) begin
      state_q <= IDLE;
    end
  end
`ifdef BITREV_PALCNT_EN
  logic [PAL_CNT_W-1:0] pal_q;
  // count delivered palindromes, sticking at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pal_q <= '0;
    else if (out_acc && bus.palind && pal_q != '1) pal_q <= pal_q + 1'b1;
  end
  assign bus.pal_cnt = pal_q;
`else
  assign bus.pal_cnt = '0;
`endif
endmodule

// File: tb/tb_bitrev_stream.sv
// tb_bitrev_stream: randomized self-checking bench for bitrev_stream against a group-reversal reference model
module tb_bitrev_stream;
  logic clk = 0;
  logic rst;
  int pass_n = 0;
  int total_n = 0;
  always #5 clk = ~clk;
  bitrev_stream_if #(.W(8)) b1 ();
  bitrev_stream_if #(.W(8)) b4 ();
  bitrev_stream #(.W(8), .G(1)) dut (.clk(clk), .rst(rst), .bus(b1));
  bitrev_stream #(.W(8), .G(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  function automatic logic [7:0] ref_rev(input logic [7:0] d, input int g);
    logic [7:0] r = '0;
    for (int k = 0; k < 8 / g; k++)
      for (int b = 0; b < g; b++) r[(8/g-1-k)*g+b] = d[k*g+b];
    return r;
  endfunction

  task automatic run_one(input logic [7:0] w, input logic m, output int lat, output bit rdy_seen);
    b1.in_valid = 1; b1.in_data = w; b1.mode = m;
    @(negedge clk);
    b1.in_valid = 0; lat = 1; rdy_seen = 0;
    while (!b1.out_valid && lat < 40) begin
      rdy_seen |= b1.in_ready;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    total_n++; if (b1.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", b1.out_valid); else pass_n++;
    total_n++; if (b1.rev !== 8'h00) $display("FAIL rst_rev got %h exp 00", b1.rev); else pass_n++;
    total_n++; if (b1.palind !== 1'b0) $display("FAIL rst_palind got %b exp 0", b1.palind); else pass_n++;
    total_n++; if (b1.pal_cnt !== 16'h0) $display("FAIL rst_pal_cnt got %h exp 0", b1.pal_cnt); else pass_n++;
    rst = 0;
    total_n++; if (b1.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", b1.in_ready); else pass_n++;
  endtask

  task automatic test_vectors;
    int lat;
    bit rdy;
    run_one(8'b1101_0010, 1'b0, lat, rdy);
    total_n++; if (lat != 1) $display("FAIL par_lat got %0d exp 1", lat); else pass_n++;
    total_n++; if (b1.rev !== 8'b0100_1011) $display("FAIL par_rev got %h exp 4b", b1.rev); else pass_n++;
    total_n++; if (b1.palind !== 1'b0) $display("FAIL par_palind got %b exp 0", b1.palind); else pass_n++;
    @(negedge clk);
    run_one(8'b1000_0001, 1'b1, lat, rdy);
    total_n++; if (lat != 9) $display("FAIL ser_lat got %0d exp 9", lat); else pass_n++;
    total_n++; if (b1.rev !== 8'h81) $display("FAIL ser_rev got %h exp 81", b1.rev); else pass_n++;
    total_n++; if (b1.palind !== 1'b1) $display("FAIL ser_palind got %b exp 1", b1.palind); else pass_n++;
    total_n++; if (rdy !== 1'b0) $display("FAIL ser_in_ready_during_shift got %b exp 0", rdy); else pass_n++;
    @(negedge clk);
  endtask

  task automatic test_group4;
    logic [7:0] ins [2] = '{8'hA5, 8'h66};
    logic [7:0] exps [2] = '{8'h5A, 8'h66};
    logic pals [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      b4.in_valid = 1; b4.in_data = ins[i]; b4.mode = 1'b0;
      @(negedge clk);
      b4.in_valid = 0;
      total_n++; if (b4.out_valid !== 1'b1) $display("FAIL g4_out_valid[%0d] got %b exp 1", i, b4.out_valid); else pass_n++;
      total_n++; if (b4.rev !== exps[i]) $display("FAIL g4_rev[%0d] got %h exp %h", i, b4.rev, exps[i]); else pass_n++;
      total_n++; if (b4.palind !== pals[i]) $display("FAIL g4_palind[%0d] got %b exp %b", i, b4.palind, pals[i]); else pass_n++;
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    int lat;
    bit rdy;
    logic [7:0] w;
    logic m;
    for (int i = 0; i < 24; i++) begin
      w = 8'($urandom);
      if (i % 6 == 0) w = ref_rev({4'($urandom), 4'h0}, 1) | {4'h0, 4'(w)};
      m = 1'($urandom);
      run_one(w, m, lat, rdy);
      total_n++; if (lat != (m ? 9 : 1)) $display("FAIL rnd_lat[%0d] got %0d exp %0d", i, lat, m ? 9 : 1); else pass_n++;
      total_n++; if (b1.rev !== ref_rev(w, 1)) $display("FAIL rnd_rev[%0d] in %h mode %b got %h exp %h", i, w, m, b1.rev, ref_rev(w, 1)); else pass_n++;
      total_n++; if (b1.palind !== (ref_rev(w, 1) == w)) $display("FAIL rnd_palind[%0d] in %h got %b exp %b", i, w, b1.palind, ref_rev(w, 1) == w); else pass_n++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w1 = 8'h3C ^ 8'($urandom_range(1, 255));
    logic [7:0] w2 = 8'($urandom);
    logic [7:0] w3 = 8'($urandom);
    bit ok = 1;
    int lat;
    b1.out_ready = 0;
    b1.in_valid = 1; b1.in_data = w1; b1.mode = 1'b0;
    @(negedge clk);
    b1.in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      ok &= b1.out_valid === 1'b1 && b1.in_ready === 1'b0 && b1.rev === ref_rev(w1, 1) && b1.palind === (ref_rev(w1, 1) == w1);
      @(negedge clk);
    end
    total_n++; if (!ok) $display("FAIL stall_hold got rev %h in_ready %b exp rev %h in_ready 0", b1.rev, b1.in_ready, ref_rev(w1, 1)); else pass_n++;
    b1.out_ready = 1; b1.in_valid = 1; b1.in_data = w2; b1.mode = 1'b0;
    #1;
    total_n++; if (b1.in_ready !== 1'b1) $display("FAIL b2b_in_ready got %b exp 1", b1.in_ready); else pass_n++;
    @(negedge clk);
    total_n++; if (b1.out_valid !== 1'b1 || b1.rev !== ref_rev(w2, 1)) $display("FAIL b2b_par got valid %b rev %h exp 1 %h", b1.out_valid, b1.rev, ref_rev(w2, 1)); else pass_n++;
    b1.in_data = w3; b1.mode = 1'b1;
    @(negedge clk);
    b1.in_valid = 0; lat = 1;
    while (!b1.out_valid && lat < 40) begin @(negedge clk); lat++; end
    total_n++; if (lat != 9 || b1.rev !== ref_rev(w3, 1)) $display("FAIL b2b_ser got lat %0d rev %h exp 9 %h", lat, b1.rev, ref_rev(w3, 1)); else pass_n++;
    @(negedge clk);
  endtask

  task automatic test_reset_midshift;
    int lat;
    bit rdy;
    bit seen = 0;
    logic [7:0] w = 8'($urandom_range(1, 254));
    b1.in_valid = 1; b1.in_data = 8'hF0; b1.mode = 1'b1;
    @(negedge clk);
    b1.in_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    total_n++; if (b1.out_valid !== 1'b0 || b1.rev !== 8'h00) $display("FAIL midshift_rst got valid %b rev %h exp 0 00", b1.out_valid, b1.rev); else pass_n++;
    rst = 0;
    total_n++; if (b1.in_ready !== 1'b1) $display("FAIL midshift_in_ready got %b exp 1", b1.in_ready); else pass_n++;
    for (int i = 0; i < 12; i++) begin seen |= b1.out_valid; @(negedge clk); end
    total_n++; if (seen) $display("FAIL midshift_partial got out_valid 1 exp 0"); else pass_n++;
    run_one(w, 1'b1, lat, rdy);
    total_n++; if (lat != 9 || b1.rev !== ref_rev(w, 1)) $display("FAIL midshift_next got lat %0d rev %h exp 9 %h", lat, b1.rev, ref_rev(w, 1)); else pass_n++;
    @(negedge clk);
  endtask

  task automatic test_palcnt;
`ifdef BITREV_PALCNT_EN
    logic [7:0] ws [5] = '{8'h81, 8'h01, 8'h24, 8'h80, 8'hFF};
    int lat;
    bit rdy;
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) begin run_one(ws[i], 1'($urandom), lat, rdy); @(negedge clk); end
    total_n++; if (b1.pal_cnt !== 16'd3) $display("FAIL pal_cnt got %0d exp 3", b1.pal_cnt); else pass_n++;
    force dut.pal_q = 16'hFFFE;
    @(negedge clk);
    release dut.pal_q;
    for (int i = 0; i < 3; i++) begin run_one(8'h81, 1'b0, lat, rdy); @(negedge clk); end
    total_n++; if (b1.pal_cnt !== 16'hFFFF) $display("FAIL pal_cnt_sat got %h exp ffff", b1.pal_cnt); else pass_n++;
`else
    total_n++; if (b1.pal_cnt !== 16'h0) $display("FAIL pal_cnt_off got %h exp 0", b1.pal_cnt); else pass_n++;
    total_n++; if (b4.pal_cnt !== 16'h0) $display("FAIL pal_cnt_off_g4 got %h exp 0", b4.pal_cnt); else pass_n++;
`endif
  endtask

  initial begin
    rst = 1;
    b1.in_valid = 0; b1.in_data = '0; b1.mode = 0; b1.out_ready = 1;
    b4.in_valid = 0; b4.in_data = '0; b4.mode = 0; b4.out_ready = 1;
    @(negedge clk);
    test_reset;
    test_vectors;
    test_group4;
    test_random;
    test_back_to_back;
    test_reset_midshift;
    test_palcnt;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
